// File: rtl/alu_muldiv.sv
// Iterative radix-2 multiply / restoring divide unit.
// One result bit per RDY=1 clock, start/busy/done handshake.
module alu_muldiv #(
  parameter int dw     = 16,
  parameter bit SIGNED = 1'b1
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          RDY,
  input  logic          start,
  input  logic [1:0]    op,
  input  logic [dw-1:0] AI,
  input  logic [dw-1:0] BI,
  output logic          busy,
  output logic          done,
  output logic [dw-1:0] LO,
  output logic [dw-1:0] HI,
  output logic          Z,
  output logic          N,
  output logic          V
);

  localparam int CW = (dw > 1) ? $clog2(dw) : 1;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX,
    DONE
  } state_t;

  state_t state, state_nx;

  logic [CW-1:0] count;
  logic [dw-1:0] wa, wb, wh, wl;
  logic          div_r, neg_q, neg_r, dz, ovf;

  logic          launch, is_div, is_sgn;
  logic          a_neg, b_neg, div0, ovf_in;
  logic [dw-1:0] a_abs, b_abs;
  logic [dw-1:0] min_val;

  logic [dw:0]   mul_sum;
  logic [dw:0]   div_sh;
  logic          div_ge;
  logic [dw-1:0] div_diff;

  logic [2*dw-1:0] prod, prod_fix;
  logic [dw-1:0]   lo_n, hi_n;
  logic            z_n, n_n, v_n;

  assign busy = (state == CALC) || (state == FIX);
  assign done = (state == DONE);

  assign launch = RDY && start && ((state == IDLE) || (state == DONE));
  assign is_div = op[1];
  assign is_sgn = SIGNED && op[0];
  assign a_neg  = is_sgn && AI[dw-1];
  assign b_neg  = is_sgn && BI[dw-1];
  assign a_abs  = a_neg ? -AI : AI;
  assign b_abs  = b_neg ? -BI : BI;
  assign div0   = is_div && (BI == '0);
  assign min_val = {1'b1, {(dw-1){1'b0}}};
  assign ovf_in = is_div && is_sgn && (AI == min_val) && (BI == '1);

  assign mul_sum  = {1'b0, wh} + (wl[0] ? {1'b0, wa} : '0);
  assign div_sh   = {wh, wl[dw-1]};
  assign div_ge   = div_sh >= {1'b0, wb};
  assign div_diff = div_sh[dw-1:0] - wb;

  assign prod     = {wh, wl};
  assign prod_fix = neg_q ? -prod : prod;

  // state register; reset wins over RDY
  always_ff @(posedge clk) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nx;
  end

  // next-state decode, frozen while RDY=0
  always_comb begin
    state_nx = state;
    if (RDY) begin
      case (state)
        IDLE: if (start) state_nx = div0 ? FIX : CALC;
        CALC: if (count == '0) state_nx = FIX;
        FIX:  state_nx = DONE;
        DONE: begin
          if (start) state_nx = div0 ? FIX : CALC;
          else       state_nx = IDLE;
        end
        default: state_nx = IDLE;
      endcase
    end
  end

  // sign correction and flags for the FIX step
  always_comb begin
    lo_n = '0;
    hi_n = '0;
    v_n  = 1'b0;
    unique case (1'b1)
      dz: begin
        lo_n = wl;
        hi_n = wh;
        v_n  = 1'b1;
      end
      (div_r && !dz): begin
        lo_n = neg_q ? -wl : wl;
        hi_n = neg_r ? -wh : wh;
        v_n  = ovf;
      end
      (!div_r): begin
        lo_n = prod_fix[dw-1:0];
        hi_n = prod_fix[2*dw-1:dw];
      end
      default: ;
    endcase
    z_n = div_r ? (lo_n == '0) : ({hi_n, lo_n} == '0);
    n_n = div_r ? lo_n[dw-1] : hi_n[dw-1];
  end

  // operand latch, iteration and result registers
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      count <= '0;
      wa    <= '0;
      wb    <= '0;
      wh    <= '0;
      wl    <= '0;
      div_r <= 1'b0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
      dz    <= 1'b0;
      ovf   <= 1'b0;
      LO    <= '0;
      HI    <= '0;
      Z     <= 1'b1;
      N     <= 1'b0;
      V     <= 1'b0;
    end else if (RDY) begin
      if (launch) begin
        count <= CW'(dw - 1);
        wa    <= a_abs;
        wb    <= b_abs;
        wh    <= div0 ? AI : '0;
        wl    <= div0 ? '1 : (is_div ? a_abs : b_abs);
        div_r <= is_div;
        neg_q <= a_neg ^ b_neg;
        neg_r <= a_neg;
        dz    <= div0;
        ovf   <= ovf_in;
      end else if (state == CALC) begin
        count <= count - CW'(1);
        if (div_r) begin
          wh <= div_ge ? div_diff : div_sh[dw-1:0];
          wl <= {wl[dw-2:0], div_ge};
        end else begin
          wh <= mul_sum[dw:1];
          wl <= {mul_sum[0], wl[dw-1:1]};
        end
      end
      if (state == FIX) begin
        LO <= lo_n;
        HI <= hi_n;
        Z  <= z_n;
        N  <= n_n;
        V  <= v_n;
      end
    end
  end

endmodule
